// File: rtl/waveform_meter_if.sv
// -----------------------------------------------------------------------------
// waveform_meter_if
//   Groups the sample stream and the measurement result of waveform_meter.
//   master : sample source / result consumer (drives ticks, samples, threshold)
//   slave  : the meter itself
//
//   sample_tick  one-cycle strobe qualifying sample_in
//   sample_in    waveform sample
//   threshold    rising-crossing level, read in every tick cycle
//   meas_valid   one-cycle pulse, new period/min/max available
//   period_out   ticks between consecutive rising crossings
//   min_out      minimum sample of the measured window
//   max_out      maximum sample of the measured window
//   timeout      one-cycle pulse, period counter saturated without a crossing
//   locked       high while an edge-to-edge window is being measured
//   sum_out      sum of the window samples (only with WAVEFORM_METER_SUM_EN)
//
// Optional feature macro: WAVEFORM_METER_SUM_EN
// -----------------------------------------------------------------------------
interface waveform_meter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
);
  logic                  sample_tick;
  logic [DATA_WIDTH-1:0] sample_in;
  logic [DATA_WIDTH-1:0] threshold;
  logic                  meas_valid;
  logic [CNT_WIDTH-1:0]  period_out;
  logic [DATA_WIDTH-1:0] min_out;
  logic [DATA_WIDTH-1:0] max_out;
  logic                  timeout;
  logic                  locked;
`ifdef WAVEFORM_METER_SUM_EN
  logic [DATA_WIDTH+CNT_WIDTH-1:0] sum_out;
`endif

  modport master (
    output sample_tick, sample_in, threshold,
`ifdef WAVEFORM_METER_SUM_EN
    input  sum_out,
`endif
    input  meas_valid, period_out, min_out, max_out, timeout, locked
  );

  modport slave (
    input  sample_tick, sample_in, threshold,
`ifdef WAVEFORM_METER_SUM_EN
    output sum_out,
`endif
    output meas_valid, period_out, min_out, max_out, timeout, locked
  );
endinterface

// File: rtl/waveform_meter.sv
// -----------------------------------------------------------------------------
// waveform_meter
//   Measures an 8-bit waveform sampled on sample_tick: period (in ticks)
//   between rising threshold crossings, plus min/max over each period.
//   Rising crossings are qualified by hysteresis: the signal must first fall
//   to lo_lvl = threshold - HYST (saturating at 0) before a new crossing
//   counts. Used to check AWG frequency and amplitude in hardware.
//
// Ports:
//   ref_clk  system clock
//   rst      synchronous, active-high reset
//   bus      waveform_meter_if.slave (sample stream in, results out)
//
// Optional feature macro: WAVEFORM_METER_SUM_EN
//   Adds bus.sum_out, the unsigned sum of the window samples, published
//   together with period_out so software can compute the mean.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_SEEK  | waiting for a low sample so a full rising edge is seen
// S_ARMED | low seen, waiting for the first rising crossing
// S_HIGH  | window running, signal above hysteresis band
// S_LOW   | window running, signal has gone low; next crossing closes it
// -----------------------------------------------------------------------------
module waveform_meter #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16,
  parameter int HYST       = 8
) (
  input logic             ref_clk,
  input logic             rst,
  waveform_meter_if.slave bus
);

  localparam int SUM_WIDTH = DATA_WIDTH + CNT_WIDTH;
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [DATA_WIDTH:0]   HYST_EXT = (DATA_WIDTH+1)'(HYST);

  typedef enum logic [1:0] {
    S_SEEK  = 2'd0,
    S_ARMED = 2'd1,
    S_HIGH  = 2'd2,
    S_LOW   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] run_min_q, run_min_d;
  logic [DATA_WIDTH-1:0] run_max_q, run_max_d;
  logic [CNT_WIDTH-1:0]  period_q, period_d;
  logic [DATA_WIDTH-1:0] min_q, min_d;
  logic [DATA_WIDTH-1:0] max_q, max_d;
  logic                  meas_valid_q, meas_valid_d;
  logic                  timeout_q, timeout_d;
`ifdef WAVEFORM_METER_SUM_EN
  logic [SUM_WIDTH-1:0]  run_sum_q, run_sum_d;
  logic [SUM_WIDTH-1:0]  sum_q, sum_d;
`endif

  logic                  tick;
  logic [DATA_WIDTH-1:0] sample;
  logic [DATA_WIDTH-1:0] threshold;
  logic [DATA_WIDTH:0]   thr_ext;
  logic [DATA_WIDTH:0]   lo_diff;
  logic [DATA_WIDTH-1:0] lo_lvl;
  logic                  is_low;
  logic                  is_cross;
  logic                  cnt_sat;

  assign tick      = bus.sample_tick;
  assign sample    = bus.sample_in;
  assign threshold = bus.threshold;

  // One extra bit so threshold < HYST is detected instead of wrapping.
  assign thr_ext  = {1'b0, threshold};
  assign lo_diff  = thr_ext - HYST_EXT;
  assign lo_lvl   = (thr_ext >= HYST_EXT) ? lo_diff[DATA_WIDTH-1:0] : '0;
  assign is_low   = (sample <= lo_lvl);
  assign is_cross = (sample >= threshold);
  assign cnt_sat  = (cnt_q == CNT_MAX);

  always_ff @(posedge ref_clk) begin
    if (rst) begin
      state_q      <= S_SEEK;
      cnt_q        <= '0;
      run_min_q    <= '0;
      run_max_q    <= '0;
      period_q     <= '0;
      min_q        <= '0;
      max_q        <= '0;
      meas_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
`ifdef WAVEFORM_METER_SUM_EN
      run_sum_q    <= '0;
      sum_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      run_min_q    <= run_min_d;
      run_max_q    <= run_max_d;
      period_q     <= period_d;
      min_q        <= min_d;
      max_q        <= max_d;
      meas_valid_q <= meas_valid_d;
      timeout_q    <= timeout_d;
`ifdef WAVEFORM_METER_SUM_EN
      run_sum_q    <= run_sum_d;
      sum_q        <= sum_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    run_min_d    = run_min_q;
    run_max_d    = run_max_q;
    period_d     = period_q;
    min_d        = min_q;
    max_d        = max_q;
    meas_valid_d = 1'b0;
    timeout_d    = 1'b0;
`ifdef WAVEFORM_METER_SUM_EN
    run_sum_d    = run_sum_q;
    sum_d        = sum_q;
`endif

    if (tick) begin
      unique case (state_q)
        S_SEEK: begin
          if (is_low) state_d = S_ARMED;
        end

        S_ARMED: begin
          if (is_cross) begin
            state_d   = S_HIGH;
            cnt_d     = CNT_ONE;
            run_min_d = sample;
            run_max_d = sample;
`ifdef WAVEFORM_METER_SUM_EN
            run_sum_d = SUM_WIDTH'(sample);
`endif
          end
        end

        S_HIGH, S_LOW: begin
          if (state_q == S_LOW && is_cross) begin
            // Crossing B closes the window (A..B-1) and opens the next one
            // with B as its first sample.
            period_d     = cnt_q;
            min_d        = run_min_q;
            max_d        = run_max_q;
            meas_valid_d = 1'b1;
            state_d      = S_HIGH;
            cnt_d        = CNT_ONE;
            run_min_d    = sample;
            run_max_d    = sample;
`ifdef WAVEFORM_METER_SUM_EN
            sum_d        = run_sum_q;
            run_sum_d    = SUM_WIDTH'(sample);
`endif
          end else if (cnt_sat) begin
            // No room for another tick: drop the window, keep last results.
            timeout_d = 1'b1;
            state_d   = S_SEEK;
            cnt_d     = '0;
          end else begin
            cnt_d     = cnt_q + CNT_ONE;
            run_min_d = (sample < run_min_q) ? sample : run_min_q;
            run_max_d = (sample > run_max_q) ? sample : run_max_q;
`ifdef WAVEFORM_METER_SUM_EN
            run_sum_d = run_sum_q + SUM_WIDTH'(sample);
`endif
            // Re-crossing while high is not a new edge; only going low is.
            if (state_q == S_HIGH && is_low) state_d = S_LOW;
          end
        end

        default: state_d = S_SEEK;
      endcase
    end
  end

  assign bus.meas_valid = meas_valid_q;
  assign bus.timeout    = timeout_q;
  assign bus.period_out = period_q;
  assign bus.min_out    = min_q;
  assign bus.max_out    = max_q;
  assign bus.locked     = (state_q == S_HIGH) || (state_q == S_LOW);
`ifdef WAVEFORM_METER_SUM_EN
  assign bus.sum_out    = sum_q;
`endif

endmodule

// File: tb/tb_waveform_meter.sv
// -----------------------------------------------------------------------------
// tb_waveform_meter
//   Two meters share one sample stream: dut16 (CNT_WIDTH=16) for the period,
//   min/max and hysteresis cases, dut4 (CNT_WIDTH=4) for counter saturation.
//   Each has its own tick so only the intended meter advances. Expected
//   results are queued as stimulus is issued; a monitor per meter pops and
//   compares whenever meas_valid or timeout appears. Non-tick cycles carry
//   random samples to show that only tick cycles matter.
// -----------------------------------------------------------------------------
module tb_waveform_meter;

  localparam int DW = 8;

  logic ref_clk = 1'b0;
  logic rst     = 1'b1;

  always #5 ref_clk = ~ref_clk;

  waveform_meter_if #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) bus16 ();
  waveform_meter_if #(.DATA_WIDTH(DW), .CNT_WIDTH(4))  bus4 ();

  waveform_meter #(.DATA_WIDTH(DW), .CNT_WIDTH(16), .HYST(8)) dut16 (
    .ref_clk (ref_clk),
    .rst     (rst),
    .bus     (bus16)
  );

  waveform_meter #(.DATA_WIDTH(DW), .CNT_WIDTH(4), .HYST(8)) dut4 (
    .ref_clk (ref_clk),
    .rst     (rst),
    .bus     (bus4)
  );

  typedef struct {
    bit is_to;
    int period;
    int mn;
    int mx;
    int sum;
  } exp_t;

  exp_t q16[$];
  exp_t q4[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  logic [63:0] sum16, sum4;
`ifdef WAVEFORM_METER_SUM_EN
  assign sum16 = 64'(bus16.sum_out);
  assign sum4  = 64'(bus4.sum_out);
`else
  assign sum16 = 64'd0;
  assign sum4  = 64'd0;
`endif

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk_meas(input int p, input int mn, input int mx, input int sm);
    exp_t e;
    e.is_to  = 1'b0;
    e.period = p;
    e.mn     = mn;
    e.mx     = mx;
    e.sum    = sm;
    return e;
  endfunction

  function automatic exp_t mk_to();
    exp_t e;
    e.is_to  = 1'b1;
    e.period = 0;
    e.mn     = 0;
    e.mx     = 0;
    e.sum    = 0;
    return e;
  endfunction

  task automatic score(input string tag, input exp_t e, input logic mv, input logic to,
                       input logic [63:0] per, input logic [63:0] mn,
                       input logic [63:0] mx, input logic [63:0] sm);
    cmp({tag, "_timeout"}, 64'(to), 64'(e.is_to));
    cmp({tag, "_meas_valid"}, 64'(mv), 64'(!e.is_to));
    if (!e.is_to) begin
      cmp({tag, "_period"}, per, 64'(e.period));
      cmp({tag, "_min"}, mn, 64'(e.mn));
      cmp({tag, "_max"}, mx, 64'(e.mx));
`ifdef WAVEFORM_METER_SUM_EN
      cmp({tag, "_sum"}, sm, 64'(e.sum));
`else
      if (sm !== 64'd0) cmp({tag, "_sum_absent"}, sm, 64'd0);
`endif
    end
  endtask

  always @(posedge ref_clk) begin : mon16
    exp_t e;
    #1;
    if (bus16.meas_valid === 1'b1 || bus16.timeout === 1'b1) begin
      if (q16.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL m16_unexpected: meas_valid=%0b timeout=%0b, expected no event (t=%0t)",
                 bus16.meas_valid, bus16.timeout, $time);
      end else begin
        e = q16.pop_front();
        score("m16", e, bus16.meas_valid, bus16.timeout, 64'(bus16.period_out),
              64'(bus16.min_out), 64'(bus16.max_out), sum16);
      end
    end
  end

  always @(posedge ref_clk) begin : mon4
    exp_t e;
    #1;
    if (bus4.meas_valid === 1'b1 || bus4.timeout === 1'b1) begin
      if (q4.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL m4_unexpected: meas_valid=%0b timeout=%0b, expected no event (t=%0t)",
                 bus4.meas_valid, bus4.timeout, $time);
      end else begin
        e = q4.pop_front();
        score("m4", e, bus4.meas_valid, bus4.timeout, 64'(bus4.period_out),
              64'(bus4.min_out), 64'(bus4.max_out), sum4);
      end
    end
  end

  task automatic set_sample(input logic [DW-1:0] s);
    bus16.sample_in = s;
    bus4.sample_in  = s;
  endtask

  task automatic set_thr(input logic [DW-1:0] t);
    bus16.threshold = t;
    bus4.threshold  = t;
  endtask

  // One tick followed by three idle cycles of random samples.
  task automatic drive(input logic [DW-1:0] s, input bit t16, input bit t4);
    @(negedge ref_clk);
    bus16.sample_tick = t16;
    bus4.sample_tick  = t4;
    set_sample(s);
    @(negedge ref_clk);
    bus16.sample_tick = 1'b0;
    bus4.sample_tick  = 1'b0;
    set_sample(DW'($urandom_range(0, 255)));
    repeat (2) begin
      @(negedge ref_clk);
      set_sample(DW'($urandom_range(0, 255)));
    end
  endtask

  task automatic tick16(input logic [DW-1:0] s);
    drive(s, 1'b1, 1'b0);
  endtask

  task automatic tick4(input logic [DW-1:0] s);
    drive(s, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge ref_clk);
    rst = 1'b1;
    @(negedge ref_clk);
    rst = 1'b0;
  endtask

  task automatic check_zero16(input string tag);
    cmp({tag, "_period"}, 64'(bus16.period_out), 64'd0);
    cmp({tag, "_min"}, 64'(bus16.min_out), 64'd0);
    cmp({tag, "_max"}, 64'(bus16.max_out), 64'd0);
    cmp({tag, "_locked"}, 64'(bus16.locked), 64'd0);
    cmp({tag, "_meas_valid"}, 64'(bus16.meas_valid), 64'd0);
    cmp({tag, "_timeout"}, 64'(bus16.timeout), 64'd0);
`ifdef WAVEFORM_METER_SUM_EN
    cmp({tag, "_sum"}, sum16, 64'd0);
`endif
  endtask

  initial begin
    bus16.sample_tick = 1'b0;
    bus4.sample_tick  = 1'b0;
    set_sample('0);
    set_thr(8'd128);
    repeat (3) @(negedge ref_clk);
    rst = 1'b0;

    // Reset state of both meters
    check_zero16("rst16");
    cmp("rst4_period", 64'(bus4.period_out), 64'd0);
    cmp("rst4_locked", 64'(bus4.locked), 64'd0);
    cmp("rst4_timeout", 64'(bus4.timeout), 64'd0);

    // Ramp 0,17..238, 15 ticks per cycle; crossings at ramp index 8 (136)
    for (int i = 0; i < 60; i++) begin
      if (i > 8 && (i % 15) == 8) q16.push_back(mk_meas(15, 0, 238, 1785));
      tick16(DW'((i % 15) * 17));
      if (i == 7) cmp("ramp_locked_armed", 64'(bus16.locked), 64'd0);
      if (i == 8) cmp("ramp_locked_first_cross", 64'(bus16.locked), 64'd1);
    end
    cmp("ramp_drained", 64'(q16.size()), 64'd0);

    // Square wave: 10 x 200, 10 x 50; first crossing at tick 20
    do_reset();
    for (int i = 0; i <= 80; i++) begin
      if (i >= 40 && (i % 20) == 0) q16.push_back(mk_meas(20, 50, 200, 2500));
      tick16(((i / 10) % 2 == 0) ? 8'd200 : 8'd50);
    end
    cmp("square_drained", 64'(q16.size()), 64'd0);

    // Hysteresis: 125/130 chatter around 128 (lo_lvl 120) must not close the window
    do_reset();
    tick16(8'd50);
    tick16(8'd200);
    for (int k = 0; k < 20; k++) tick16((k % 2 == 0) ? 8'd125 : 8'd130);
    cmp("hyst_locked", 64'(bus16.locked), 64'd1);
    tick16(8'd50);
    q16.push_back(mk_meas(22, 50, 200, 2800));
    tick16(8'd200);
    cmp("hyst_drained", 64'(q16.size()), 64'd0);

    // Reset 5 ticks into the new window discards it
    repeat (4) tick16(8'd200);
    cmp("pre_rst_period", 64'(bus16.period_out), 64'd22);
    do_reset();
    check_zero16("midrst");
    tick16(8'd200);
    cmp("midrst_seek_locked", 64'(bus16.locked), 64'd0);
    tick16(8'd50);
    tick16(8'd200);
    cmp("midrst_relock", 64'(bus16.locked), 64'd1);
    tick16(8'd50);
    q16.push_back(mk_meas(2, 50, 200, 250));
    tick16(8'd200);

    // threshold below HYST: lo_lvl saturates to 0, so 3 is not low
    do_reset();
    set_thr(8'd5);
    tick16(8'd0);
    tick16(8'd10);
    tick16(8'd3);
    tick16(8'd0);
    q16.push_back(mk_meas(3, 0, 10, 13));
    tick16(8'd7);
    cmp("lowthr_drained", 64'(q16.size()), 64'd0);

    // Saturation on the 4-bit counter: one measurement, then constant high
    do_reset();
    set_thr(8'd128);
    tick4(8'd50);
    tick4(8'd200);
    tick4(8'd50);
    q4.push_back(mk_meas(2, 50, 200, 250));
    tick4(8'd200);
    for (int k = 0; k < 14; k++) tick4(8'd200);
    cmp("sat_no_early_event", 64'(q4.size()), 64'd0);
    cmp("sat_locked_before", 64'(bus4.locked), 64'd1);
    q4.push_back(mk_to());
    tick4(8'd200);
    cmp("sat_drained", 64'(q4.size()), 64'd0);
    cmp("sat_locked_after", 64'(bus4.locked), 64'd0);
    cmp("sat_period_held", 64'(bus4.period_out), 64'd2);
    cmp("sat_min_held", 64'(bus4.min_out), 64'd50);
    cmp("sat_max_held", 64'(bus4.max_out), 64'd200);
    repeat (3) tick4(8'd200);
    cmp("seek_quiet16_locked", 64'(bus16.locked), 64'd0);

    repeat (5) @(negedge ref_clk);
    cmp("final_q16_empty", 64'(q16.size()), 64'd0);
    cmp("final_q4_empty", 64'(q4.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
